// File: rtl/cpu_mem_pkg.sv
// Shared encodings for the MEM-stage load/store path: funct3/size codes,
// control enable bit positions and the access FSM state type.
package cpu_mem_pkg;

    localparam int RD_EN_BIT = 3;
    localparam int WR_EN_BIT = 2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } mau_state_e;

    function automatic logic load_f3_legal(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge port; master is the load/store unit.
interface mem_access_unit_if;

    logic [31:0] DM_ADDR;
    logic [31:0] DM_WRITE_DATA;
    logic [3:0]  DM_BYTE_EN;
    logic        DM_READ;
    logic        DM_WRITE;
    logic [31:0] DM_READ_DATA;
    logic        DM_ACK;

    modport master (
        output DM_ADDR, DM_WRITE_DATA, DM_BYTE_EN, DM_READ, DM_WRITE,
        input  DM_READ_DATA, DM_ACK
    );

    modport slave (
        input  DM_ADDR, DM_WRITE_DATA, DM_BYTE_EN, DM_READ, DM_WRITE,
        output DM_READ_DATA, DM_ACK
    );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: byte enables and replicated store data
// for the request, plus extraction and extension of the returned word.
module mem_lane_align
    import cpu_mem_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_read_word,
    output logic [3:0]  o_byte_en,
    output logic [31:0] o_store_data,
    output logic [31:0] o_load_data
);

    logic [31:0] w_shifted;

    assign w_shifted = i_read_word >> {i_addr_lo, 3'b000};

    always_comb begin
        o_byte_en    = 4'b0000;
        o_store_data = i_store_data;
        case (i_funct3[1:0])
            SZ_B: begin
                o_byte_en    = 4'b0001 << i_addr_lo;
                o_store_data = {4{i_store_data[7:0]}};
            end
            SZ_H: begin
                o_byte_en    = 4'b0011 << i_addr_lo;
                o_store_data = {2{i_store_data[15:0]}};
            end
            SZ_W:    o_byte_en = 4'b1111;
            default: o_byte_en = 4'b0000;
        endcase
    end

    always_comb begin
        o_load_data = '0;
        case (i_funct3)
            F3_LB:   o_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_LH:   o_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_LW:   o_load_data = w_shifted;
            F3_LBU:  o_load_data = {24'd0, w_shifted[7:0]};
            F3_LHU:  o_load_data = {16'd0, w_shifted[15:0]};
            default: o_load_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: issues one aligned data-memory request per
// operation, stalls the pipeline until ack or timeout, returns extended loads.
module mem_access_unit
    import cpu_mem_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [31:0]              MEM_ALU_OUT,
    input  logic [31:0]              MEM_REG_DATA2,
    input  logic [3:0]               MEM_DATA_MEM_READ,
    input  logic [2:0]               MEM_DATA_MEM_WRITE,
    mem_access_unit_if.master        dm,
    output logic [31:0]              LOAD_DATA,
    output logic                     MEM_STALL,
    output logic                     MISALIGNED,
    output logic                     BUS_ERROR
);

    localparam logic [15:0] MAX_W = 16'(MAX_WAIT);

    mau_state_e  r_state, w_state_nxt;
    logic [15:0] r_wait_cnt;
    logic [31:0] r_dm_addr, r_dm_wdata, r_load_data;
    logic [3:0]  r_dm_be;
    logic        r_dm_read, r_dm_write, r_misaligned, r_bus_error;
    logic [1:0]  r_addr_lo;
    logic [2:0]  r_f3;

    logic        w_is_load, w_is_store, w_legal, w_misal, w_go, w_in_idle, w_stall;
    logic [2:0]  w_req_f3, w_lane_f3;
    logic [1:0]  w_lane_lo;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_load_val;

    // Load takes priority when both enables are set.
    assign w_is_load  = MEM_DATA_MEM_READ[RD_EN_BIT];
    assign w_is_store = MEM_DATA_MEM_WRITE[WR_EN_BIT] & ~w_is_load;
    assign w_req_f3   = w_is_load ? MEM_DATA_MEM_READ[2:0] : {1'b0, MEM_DATA_MEM_WRITE[1:0]};
    assign w_legal    = (w_is_load & load_f3_legal(MEM_DATA_MEM_READ[2:0])) |
                        (w_is_store & (MEM_DATA_MEM_WRITE[1:0] != 2'b11));
    assign w_misal    = w_legal & (((w_req_f3[1:0] == SZ_H) & MEM_ALU_OUT[0]) |
                                   ((w_req_f3[1:0] == SZ_W) & (MEM_ALU_OUT[1:0] != 2'b00)));
    assign w_go       = w_legal & ~w_misal;
    assign w_in_idle  = (r_state == ST_IDLE);

    // Live operands steer the request in IDLE; captured ones steer the response.
    assign w_lane_lo  = w_in_idle ? MEM_ALU_OUT[1:0] : r_addr_lo;
    assign w_lane_f3  = w_in_idle ? w_req_f3 : r_f3;

    mem_lane_align u_align (
        .i_addr_lo    (w_lane_lo),
        .i_funct3     (w_lane_f3),
        .i_store_data (MEM_REG_DATA2),
        .i_read_word  (dm.DM_READ_DATA),
        .o_byte_en    (w_be),
        .o_store_data (w_wdata),
        .o_load_data  (w_load_val)
    );

    always_ff @(posedge CLK) begin
        if (RESET) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_go) begin
                    w_state_nxt = ST_ACCESS;
                    w_stall     = 1'b1;
                end
            end
            ST_ACCESS: begin
                w_stall = 1'b1;
                if (dm.DM_ACK || (r_wait_cnt == MAX_W)) w_state_nxt = ST_DONE;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wait_cnt   <= '0;
            r_dm_addr    <= '0;
            r_dm_wdata   <= '0;
            r_dm_be      <= '0;
            r_dm_read    <= 1'b0;
            r_dm_write   <= 1'b0;
            r_load_data  <= '0;
            r_misaligned <= 1'b0;
            r_bus_error  <= 1'b0;
            r_addr_lo    <= '0;
            r_f3         <= '0;
        end else begin
            r_misaligned <= 1'b0;
            r_bus_error  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_misal) begin
                        r_misaligned <= 1'b1;
                        r_load_data  <= '0;
                    end else if (w_go) begin
                        r_dm_addr  <= {MEM_ALU_OUT[31:2], 2'b00};
                        r_dm_be    <= w_be;
                        r_dm_wdata <= w_wdata;
                        r_dm_read  <= w_is_load;
                        r_dm_write <= ~w_is_load;
                        r_addr_lo  <= MEM_ALU_OUT[1:0];
                        r_f3       <= w_req_f3;
                    end
                end
                ST_ACCESS: begin
                    if (dm.DM_ACK) begin
                        if (r_dm_read) r_load_data <= w_load_val;
                        r_dm_read  <= 1'b0;
                        r_dm_write <= 1'b0;
                    end else if (r_wait_cnt == MAX_W) begin
                        r_bus_error <= 1'b1;
                        r_load_data <= '0;
                        r_dm_read   <= 1'b0;
                        r_dm_write  <= 1'b0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                    end
                end
                ST_DONE: r_wait_cnt <= '0;
                default: r_wait_cnt <= '0;
            endcase
        end
    end

    assign MEM_STALL        = w_stall & ~RESET;
    assign LOAD_DATA        = r_load_data;
    assign MISALIGNED       = r_misaligned;
    assign BUS_ERROR        = r_bus_error;
    assign dm.DM_ADDR       = r_dm_addr;
    assign dm.DM_WRITE_DATA = r_dm_wdata;
    assign dm.DM_BYTE_EN    = r_dm_be;
    assign dm.DM_READ       = r_dm_read;
    assign dm.DM_WRITE      = r_dm_write;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage load/store engine of the CPU pipeline. It consumes the EX/MEM register outputs, which are the address, the store data and the read/write control codes. It drives a request/acknowledge data-memory port with byte-lane alignment, and stalls the pipeline until the access completes. Load results are extracted from the addressed lanes, sign- or zero-extended, and presented to the MEM/WB path together with fault flags.

## Interface
- MAX_WAIT, default 255: cycles allowed in ACCESS without DM_ACK before a bus-error abort (≥1, ≤65535).
- CLK  in  1  clock, all state updates on posedge.
- RESET  in  1  synchronous, active-high reset; clock CLK.
- MEM_ALU_OUT  in  32  effective byte address.
- MEM_REG_DATA2  in  32  store data, right-aligned.
- MEM_DATA_MEM_READ  in  4  bit3 = load enable; bits[2:0] = funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others illegal).
- MEM_DATA_MEM_WRITE  in  3  bit2 = store enable; bits[1:0] = size (00 SB, 01 SH, 10 SW; 11 illegal).
- DM_ADDR  out  32  word address, bits[1:0] always 0.
- DM_WRITE_DATA  out  32  store data shifted into lanes.
- DM_BYTE_EN  out  4  active lanes, for both reads and writes.
- DM_READ  out  1  read request, held until ack.
- DM_WRITE  out  1  write request, held until ack.
- DM_READ_DATA  in  32  read word, valid when DM_ACK=1.
- DM_ACK  in  1  single-cycle completion from memory.
- LOAD_DATA  out  32  extended load result.
- MEM_STALL  out  1  freeze upstream stages and the EX/MEM register.
- MISALIGNED  out  1  one-cycle fault pulse.
- BUS_ERROR  out  1  one-cycle timeout pulse.

## Operation
- **FSM states:** IDLE, ACCESS, DONE.
- **Operation present:** READ[3] or WRITE[2] is set. If both are set, the access is a load and no write is issued.
- **Legality check (IDLE):**
  - An illegal funct3 or size is treated as no operation.
  - Misalignment is defined as a halfword with addr[0]=1, or a word with addr[1:0]≠0.
  - A misaligned access pulses MISALIGNED for exactly one cycle, stays in IDLE, issues no request and does not assert MEM_STALL.
  - After a misaligned access, LOAD_DATA=0.
- **IDLE → ACCESS:** taken on a legal operation. On that edge the unit registers DM_ADDR, DM_BYTE_EN and DM_WRITE_DATA, and raises DM_READ or DM_WRITE.
- **Byte enables:**
  - Byte: 0001<<addr[1:0].
  - Half: 0011<<addr[1:0].
  - Word: 1111.
- **Store data lanes:** the byte is replicated across all lanes; the half is replicated to both halves; the word passes through unchanged.
- **ACCESS:**
  - Requests and registered outputs are held stable.
  - The wait counter increments every cycle.
  - On DM_ACK: for loads, LOAD_DATA is registered from DM_READ_DATA shifted right by addr[1:0]*8, then extended per funct3. Then → DONE.
  - If the counter reaches MAX_WAIT without ack: BUS_ERROR pulses, LOAD_DATA=0, → DONE.
- **Request deassertion:** DM_READ and DM_WRITE drop on the edge that leaves ACCESS.
- **DONE:** MEM_STALL=0, so the pipeline advances. → IDLE unconditionally, and the counter is cleared.
- **MEM_STALL:** combinational. It equals (IDLE and legal operation) or ACCESS, and is forced to 0 while RESET=1.
- **Late ack:** a DM_ACK received in IDLE or DONE is ignored.

## Timing
- **Reset values:** state IDLE, counter 0, and every registered output 0 (DM_ADDR, DM_WRITE_DATA, DM_BYTE_EN, DM_READ, DM_WRITE, LOAD_DATA, MISALIGNED, BUS_ERROR).
- **Reset mid-ACCESS:** the request drops on the reset edge, and the access is abandoned with no ack and no pulse.
- **Minimum latency:** 3 cycles per access.
  - Cycle 0: IDLE, stall asserted.
  - Cycle 1: ACCESS with ack present.
  - Cycle 2: DONE; LOAD_DATA is valid and stall is low.
- **Stall duration:** with ack arriving k cycles after the request rises, MEM_STALL is high for k+1 cycles.
- **Timeout timing:** BUS_ERROR is asserted in DONE, MAX_WAIT+1 cycles after the request rose.
- **LOAD_DATA hold:** LOAD_DATA holds its value until the next load completes.
- **Back-to-back operations:** the next operation is sampled in IDLE, the cycle after DONE.

## Structure
- **Shared package `cpu_mem_pkg`:**
  - funct3 load codes and store size codes.
  - The FSM state enum.
  - Enable bit positions (READ[3], WRITE[2]).
- **Sub-module `mem_lane_align`:** purely combinational. It takes addr[1:0], size/funct3, store data and read word, and produces byte enables, shifted store data and the extended load value.

## Test plan
- **LW, immediate ack:** LW at addr 0x100 with ack in the first ACCESS cycle, DM_READ_DATA=0xDEADBEEF → DM_ADDR=0x100, BE=1111; LOAD_DATA=0xDEADBEEF in DONE; MEM_STALL high for exactly 2 cycles.
- **LB / LBU extension:** LB at 0x103 with read word 0x80FF1234 → BE=1000, LOAD_DATA=0xFFFFFF80. LBU at the same address → 0x00000080.
- **SH, delayed ack:** SH at 0x202 with data 0x0000ABCD, ack after 4 cycles → DM_ADDR=0x200, BE=1100, DM_WRITE_DATA=0xABCDABCD; DM_WRITE held 4 cycles; stall 5 cycles.
- **Misaligned LW:** LW at 0x101 → MISALIGNED pulses 1 cycle; no DM_READ; MEM_STALL never high; LOAD_DATA=0.
- **Timeout:** MAX_WAIT=8 with no ack → BUS_ERROR pulses 9 cycles after DM_READ rose; DM_READ drops; LOAD_DATA=0; FSM returns to IDLE.
- **Reset mid-access:** RESET asserted 2 cycles into ACCESS → on the next edge all outputs are 0 and state is IDLE; a later ack has no effect.
